// File: rtl/serial_fxp_mul_if.sv
// rtl/serial_fxp_mul_if.sv - operand, result and handshake bundle for serial_fxp_mul
// Ports (signals):
//   x, y                      operands, WIDTH bits
//   data_x_vld / data_x_rdy   x channel handshake
//   data_y_vld / data_y_rdy   y channel handshake
//   product                   full-precision product, 2*WIDTH bits
//   result, ovf               Q-format result and saturation flag
//   d_out_vld / d_out_rdy     result channel handshake
// Modports: slave = multiplier side, master = operand source / result sink side.
interface serial_fxp_mul_if #(
  parameter int WIDTH = 8
) ();
  logic [WIDTH-1:0]   x;
  logic [WIDTH-1:0]   y;
  logic               data_x_vld;
  logic               data_x_rdy;
  logic               data_y_vld;
  logic               data_y_rdy;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   result;
  logic               ovf;
  logic               d_out_vld;
  logic               d_out_rdy;

  modport slave (
    input  x, y, data_x_vld, data_y_vld, d_out_rdy,
    output data_x_rdy, data_y_rdy, product, result, ovf, d_out_vld
  );

  modport master (
    output x, y, data_x_vld, data_y_vld, d_out_rdy,
    input  data_x_rdy, data_y_rdy, product, result, ovf, d_out_vld
  );
endinterface

// File: rtl/serial_fxp_mul.sv
// rtl/serial_fxp_mul.sv - serial shift-add multiplier with Q-format rounding and saturation
// Ports:
//   clk         clock, all state on rising edge
//   asyn_reset  synchronous active-high reset (name kept for compatibility)
//   bus         serial_fxp_mul_if.slave: x/y operand channels, product/result/ovf output channel
// Parameters: WIDTH operand width (>= 2), FRAC fractional bits, SIGNED 1 = two's complement.
// Build option: SERIAL_FXP_MUL_ROUND_EN selects round-half-up instead of truncation for result.
module serial_fxp_mul #(
  parameter int WIDTH  = 8,
  parameter int FRAC   = 0,
  parameter int SIGNED = 0
) (
  input  logic            clk,
  input  logic            asyn_reset,
  serial_fxp_mul_if.slave bus
);

  localparam int CW  = $clog2(WIDTH);
  localparam int PW  = 2 * WIDTH;
  // Two guard bits: one for the rounding carry, one so unsigned values stay positive when signed.
  localparam int EW  = 2 * WIDTH + 2;
  localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;
  localparam logic signed [EW-1:0] ONE = EW'(1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] x_reg, y_reg;
  logic             x_held, y_held;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    acc, acc_nxt, x_ext, addend;
  logic [PW-1:0]    product_r;
  logic [WIDTH-1:0] result_r, res_nxt;
  logic             ovf_r, ovf_nxt;
  logic             x_rdy, y_rdy, x_fire, y_fire, both_held, last_step;

  logic signed [EW-1:0] ext, rnd, shf, hi, lo;

  // Ready depends only on state and held flags, never on an input valid.
  assign x_rdy     = !asyn_reset && (state == IDLE) && !x_held;
  assign y_rdy     = !asyn_reset && (state == IDLE) && !y_held;
  assign x_fire    = bus.data_x_vld && x_rdy;
  assign y_fire    = bus.data_y_vld && y_rdy;
  assign both_held = (x_held || x_fire) && (y_held || y_fire);
  assign last_step = (cnt == CW'(WIDTH - 1));

  assign bus.data_x_rdy = x_rdy;
  assign bus.data_y_rdy = y_rdy;
  assign bus.d_out_vld  = !asyn_reset && (state == DONE);
  assign bus.product    = product_r;
  assign bus.result     = result_r;
  assign bus.ovf        = ovf_r;

  always_ff @(posedge clk) begin
    if (asyn_reset) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (both_held)     state_nxt = CALC;
      CALC:    if (last_step)     state_nxt = DONE;
      DONE:    if (bus.d_out_rdy) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // One partial product per cycle; the MSB of a two's-complement multiplier carries
  // negative weight, so its step subtracts.
  always_comb begin
    x_ext   = (SIGNED != 0) ? {{WIDTH{x_reg[WIDTH-1]}}, x_reg} : {{WIDTH{1'b0}}, x_reg};
    addend  = y_reg[cnt] ? (x_ext << cnt) : '0;
    acc_nxt = ((SIGNED != 0) && last_step) ? acc - addend : acc + addend;
  end

  // Result derived from the final accumulator value so it registers alongside product.
  always_comb begin
    ext = (SIGNED != 0) ? {{2{acc_nxt[PW-1]}}, acc_nxt} : {2'b00, acc_nxt};
`ifdef SERIAL_FXP_MUL_ROUND_EN
    rnd = ext + ((FRAC > 0) ? (ONE <<< RSH) : EW'(0));
`else
    rnd = ext;
`endif
    shf = rnd >>> FRAC;
    hi  = (SIGNED != 0) ? (ONE <<< (WIDTH - 1)) - ONE : (ONE <<< WIDTH) - ONE;
    lo  = (SIGNED != 0) ? -(ONE <<< (WIDTH - 1)) : EW'(0);
    res_nxt = shf[WIDTH-1:0];
    ovf_nxt = 1'b0;
    if (shf > hi) begin
      res_nxt = hi[WIDTH-1:0];
      ovf_nxt = 1'b1;
    end else if (shf < lo) begin
      res_nxt = lo[WIDTH-1:0];
      ovf_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (asyn_reset) begin
      x_reg     <= '0;
      y_reg     <= '0;
      x_held    <= 1'b0;
      y_held    <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      product_r <= '0;
      result_r  <= '0;
      ovf_r     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (x_fire) begin
            x_reg  <= bus.x;
            x_held <= 1'b1;
          end
          if (y_fire) begin
            y_reg  <= bus.y;
            y_held <= 1'b1;
          end
          if (both_held) begin
            cnt <= '0;
            acc <= '0;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
          if (last_step) begin
            product_r <= acc_nxt;
            result_r  <= res_nxt;
            ovf_r     <= ovf_nxt;
          end
        end
        DONE: begin
          if (bus.d_out_rdy) begin
            x_held <= 1'b0;
            y_held <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_fxp_mul.sv
// tb/tb_serial_fxp_mul.sv - scoreboard bench for serial_fxp_mul in three configurations
module tb_serial_fxp_mul;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] x_d = '0, y_d = '0;
  logic       x_v = 1'b0, y_v = 1'b0, out_rdy = 1'b0;
  bit         rnd_rdy = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  logic [24:0] q0[$], q1[$], q2[$];

  always #5 clk = ~clk;

  serial_fxp_mul_if #(.WIDTH(8)) b0 (), b1 (), b2 ();

  assign b0.x = x_d;  assign b0.y = y_d;
  assign b0.data_x_vld = x_v;  assign b0.data_y_vld = y_v;  assign b0.d_out_rdy = out_rdy;
  assign b1.x = x_d;  assign b1.y = y_d;
  assign b1.data_x_vld = x_v;  assign b1.data_y_vld = y_v;  assign b1.d_out_rdy = out_rdy;
  assign b2.x = x_d;  assign b2.y = y_d;
  assign b2.data_x_vld = x_v;  assign b2.data_y_vld = y_v;  assign b2.d_out_rdy = out_rdy;

  serial_fxp_mul #(.WIDTH(8), .FRAC(0), .SIGNED(0)) u_u0 (.clk(clk), .asyn_reset(rst), .bus(b0.slave));
  serial_fxp_mul #(.WIDTH(8), .FRAC(0), .SIGNED(1)) u_s0 (.clk(clk), .asyn_reset(rst), .bus(b1.slave));
  serial_fxp_mul #(.WIDTH(8), .FRAC(4), .SIGNED(1)) u_s4 (.clk(clk), .asyn_reset(rst), .bus(b2.slave));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: integer product, floor (or round-half-up) division by 2^FRAC, clamp.
  function automatic logic [24:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input bit sg, input int fr);
    longint pa, pb, p, r, lo, hi;
    logic [63:0] pv, rv;
    bit o;
    pa = sg ? longint'($signed(a)) : longint'(a);
    pb = sg ? longint'($signed(b)) : longint'(b);
    p  = pa * pb;
    r  = p;
`ifdef SERIAL_FXP_MUL_ROUND_EN
    if (fr > 0) r = r + (longint'(1) << (fr - 1));
`endif
    r  = r >>> fr;
    lo = sg ? -128 : 0;
    hi = sg ? 127 : 255;
    o  = 1'b0;
    if (r > hi) begin r = hi; o = 1'b1; end
    if (r < lo) begin r = lo; o = 1'b1; end
    pv = p;
    rv = r;
    return {o, rv[7:0], pv[15:0]};
  endfunction

  task automatic set_rdy(input logic v);
    @(posedge clk);
    #1 out_rdy = v;
  endtask

  // Called at a negedge; returns at the negedge following the capture of the later operand.
  task automatic send(input logic [7:0] xv, input logic [7:0] yv, input int ydly);
    bit gx = 1'b0, gy = 1'b0;
    int cyc = 0;
    x_d = xv; y_d = yv; x_v = 1'b1; y_v = (ydly == 0);
    while (!(gx && gy) && cyc < 300) begin
      if (x_v && b0.data_x_rdy) gx = 1'b1;
      if (y_v && b0.data_y_rdy) gy = 1'b1;
      @(negedge clk);
      cyc++;
      if (gx) begin
        x_v = 1'b0;
        if (!gy) chk("x_rdy_low_while_held", b0.data_x_rdy, 0);
      end
      if (gy) y_v = 1'b0;
      if (!gy && cyc >= ydly) y_v = 1'b1;
    end
    if (!(gx && gy)) chk("capture_timeout", cyc, 0);
    else begin
      q0.push_back(model(xv, yv, 1'b0, 0));
      q1.push_back(model(xv, yv, 1'b1, 0));
      q2.push_back(model(xv, yv, 1'b1, 4));
    end
  endtask

  task automatic check_latency();
    int k = 0;
    while (!b0.d_out_vld && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("latency", k, 8);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_rdy = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: a transfer happens at the next posedge when vld and rdy are both high now.
  initial begin
    logic [24:0] e;
    forever begin
      @(negedge clk);
      if (!rst && b0.d_out_vld && out_rdy) begin
        chk("vld_align", {b1.d_out_vld, b2.d_out_vld}, 2'b11);
        if (q0.size() == 0) chk("unexpected_output", q0.size(), 1);
        else begin
          e = q0.pop_front();
          chk("u0_product", b0.product, e[15:0]);
          chk("u0_result",  b0.result,  e[23:16]);
          chk("u0_ovf",     b0.ovf,     e[24]);
          e = q1.pop_front();
          chk("s0_product", b1.product, e[15:0]);
          chk("s0_result",  b1.result,  e[23:16]);
          chk("s0_ovf",     b1.ovf,     e[24]);
          e = q2.pop_front();
          chk("s4_product", b2.product, e[15:0]);
          chk("s4_result",  b2.result,  e[23:16]);
          chk("s4_ovf",     b2.ovf,     e[24]);
        end
      end
    end
  end

  initial begin
    logic [7:0]  dx[8];
    logic [7:0]  dy[8];
    logic [15:0] p0, p2;
    logic [7:0]  r2;
    int          w;
    dx = '{8'h03, 8'hFE, 8'h80, 8'h18, 8'h13, 8'h7F, 8'h80, 8'hFF};
    dy = '{8'h05, 8'h03, 8'h80, 8'h28, 8'h13, 8'h7F, 8'h7F, 8'hFF};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {b0.data_x_rdy, b0.data_y_rdy, b0.d_out_vld, b0.product, b0.result, b0.ovf}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_reset", {b0.data_x_rdy, b0.data_y_rdy}, 2'b11);

    set_rdy(1'b1);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      send(dx[i], dy[i], 0);
      check_latency();
    end

    send(8'h5A, 8'h33, 3);
    check_latency();

    set_rdy(1'b0);
    @(negedge clk);
    send(8'hA7, 8'h6C, 0);
    check_latency();
    p0 = b0.product; p2 = b2.product; r2 = b2.result;
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold", {b0.d_out_vld, b0.data_x_rdy, b0.data_y_rdy, b0.product, b2.product, b2.result},
          {3'b100, p0, p2, r2});
    end
    set_rdy(1'b1);
    @(negedge clk);
    @(negedge clk);
    chk("vld_drop", {b0.d_out_vld, b0.data_x_rdy, b0.data_y_rdy}, 3'b011);

    send(8'h77, 8'h99, 0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {b0.d_out_vld, b0.data_x_rdy, b0.data_y_rdy, b0.product, b2.result, b2.ovf}, 0);
    rst = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    #1;
    chk("rdy_after_abort", {b0.data_x_rdy, b0.data_y_rdy}, 2'b11);
    @(negedge clk);
    send(8'h02, 8'h04, 0);
    check_latency();

    rnd_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send(8'($urandom), 8'($urandom), $urandom_range(0, 3));
    end

    w = 0;
    while (q0.size() != 0 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("drain", q0.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
